// File: rtl/modular_multiplication.sv
// Bit-serial MSB-first interleaved modular multiplier: p = (a*b) mod m.
// Processes one bit of a per clock, so latency is constant and independent of the operand values.
module modular_multiplication #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p,
  output logic             ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic             ready_q, ready_d;

  logic [EW-1:0]    modExt;
  logic [EW-1:0]    t1;
  logic [EW-1:0]    t1Red;
  logic [EW-1:0]    t2;
  logic             t2Geq;
  logic [WIDTH-1:0] accNext;

  // One iteration: double, reduce, conditionally add b, reduce again.
  // Only the low WIDTH bits survive the final subtraction, so it is done at WIDTH bits.
  always_comb begin
    modExt = {2'b00, mod_q};
    t1     = {1'b0, acc_q, 1'b0};
    t1Red  = t1;
    if (t1 >= modExt) begin
      t1Red = t1 - modExt;
    end
    t2      = t1Red + (opA_q[bitCnt_q] ? {2'b00, opB_q} : {EW{1'b0}});
    t2Geq   = (t2 >= modExt);
    accNext = t2[WIDTH-1:0] - (t2Geq ? mod_q : {WIDTH{1'b0}});
  end

  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    mod_d    = mod_q;
    acc_d    = acc_q;
    result_d = result_q;
    bitCnt_d = bitCnt_q;
    ready_d  = ready_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opA_d    = a;
          opB_d    = b;
          mod_d    = m;
          acc_d    = '0;
          bitCnt_d = CW'(WIDTH - 1);
          ready_d  = 1'b0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = accNext;
        if (bitCnt_q == '0) begin
          result_d = accNext;
          ready_d  = 1'b1;
          state_d  = DONE;
        end else begin
          bitCnt_d = bitCnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      bitCnt_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      bitCnt_q <= bitCnt_d;
      ready_q  <= ready_d;
    end
  end

  assign p     = result_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_modular_multiplication.sv
// Scoreboard bench for modular_multiplication: expected results come from wide-integer (a*b)%m
// and are queued at issue time; a monitor pops one per rising edge of ready.
module tb_modular_multiplication;

  localparam int W = 256;
  localparam logic [W-1:0] P256 = {{31{8'hFF}}, 8'h43};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] aIn, bIn, mIn;
  logic [W-1:0] p;
  logic         ready;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] expQ[$];

  modular_multiplication #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (aIn),
    .b    (bIn),
    .m    (mIn),
    .p    (p),
    .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] refModMul(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [W-1:0] md);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] rem;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    rem  = prod % {{W{1'b0}}, md};
    return rem[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Pulse start for one edge, then scramble the inputs: the DUT must use its latched copy.
  task automatic startPulse(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] md);
    @(negedge clk);
    aIn = x; bIn = y; mIn = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    aIn = rand256(); bIn = rand256(); mIn = rand256();
  endtask

  // k0 = edges already elapsed since the start edge; ready must rise on edge W after it.
  task automatic waitReady(input int k0, input string name);
    int k;
    k = k0;
    while (ready !== 1'b1 && k < W + 20) begin
      @(negedge clk);
      k++;
    end
    checkInt(name, k, W);
  endtask

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] md);
    expQ.push_back(refModMul(x, y, md));
    startPulse(x, y, md);
    waitReady(0, "latency");
  endtask

  // Monitor: every rising edge of ready must match the oldest outstanding expectation.
  initial begin
    logic         prevReady;
    logic [W-1:0] e;
    prevReady = 1'b0;
    forever begin
      @(negedge clk);
      if (ready === 1'b1 && prevReady !== 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ready: got ready=1 with p=%h, expected no result", p);
        end else begin
          e = expQ.pop_front();
          checkOutput("result", p, e);
        end
      end
      prevReady = ready;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] x, y, md, firstRes;
    rst_n = 1'b1; start = 1'b0; aIn = '0; bIn = '0; mIn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_p", p, '0);
    checkOutput("reset_ready", W'(ready), '0);
    rst_n = 1'b0;

    applyStimulus(256'd3, 256'd4, 256'd5);
    checkOutput("small_3x4_mod5", p, 256'd2);

    y = rand256() % P256;
    y[3:0] = 4'h9;
    applyStimulus('0, y, P256);
    checkOutput("zero_operand", p, '0);

    applyStimulus(256'd1, 256'h1234, P256);
    checkOutput("identity", p, 256'h1234);

    applyStimulus(P256 - 1, P256 - 1, P256);
    checkOutput("boundary_m_minus_1_sq", p, 256'd1);

    applyStimulus(256'hF7E75FDC469067FFDC439B16B7D2F0FBA2F3B5A6ABF5A7E7CE0F05EDDA3C339B,
                  256'hE5A3B45D7F29DCE6E89E3F08A7F68DAE8B771B75D7422F9A63FA9D423D51D6E9, P256);

    applyStimulus('0, '0, 256'd1);
    checkOutput("mod_one", p, '0);

    // Start during CALC is ignored; then a start in DONE drops ready immediately.
    x = rand256() % P256;
    y = rand256() % P256;
    firstRes = refModMul(x, y, P256);
    expQ.push_back(firstRes);
    startPulse(x, y, P256);
    repeat (99) @(negedge clk);
    aIn = 256'd3; bIn = 256'd4; mIn = 256'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitReady(100, "latency_with_ignored_start");
    expQ.push_back(256'd5);
    startPulse(256'd3, 256'd4, 256'd7);
    checkOutput("ready_drops_on_restart", W'(ready), '0);
    checkOutput("p_holds_on_restart", p, firstRes);
    waitReady(0, "latency_restart");
    checkOutput("restart_3x4_mod7", p, 256'd5);

    // Reset mid-operation aborts the computation with no ready.
    expQ.push_back(refModMul(256'd11, 256'd13, 256'd17));
    startPulse(256'd11, 256'd13, 256'd17);
    repeat (49) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    checkOutput("midreset_p", p, '0);
    checkOutput("midreset_ready", W'(ready), '0);
    expQ.delete();
    repeat (W + 10) @(negedge clk);
    checkOutput("no_ready_after_abort", W'(ready), '0);
    applyStimulus(256'd3, 256'd4, 256'd5);
    checkOutput("after_abort_3x4_mod5", p, 256'd2);

    for (int i = 0; i < 100; i++) begin
      md = rand256();
      md[0] = i[0];
      if (md < 2) md = 256'd2;
      if (i % 10 == 0) md = P256;
      x = rand256() % md;
      y = rand256() % md;
      applyStimulus(x, y, md);
    end

    @(negedge clk);
    checkInt("scoreboard_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
